// File: rtl/vga_text_renderer_pkg.sv
// Shared constants and types for the 80x30 VGA text renderer.
// Default timing is 640x480@60 with 8x16 character cells.
package vga_text_renderer_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int VGA_COLS   = 80;
  localparam int VGA_ROWS   = 30;
  localparam int VGA_CHAR_W = 8;
  localparam int VGA_CHAR_H = 16;
  localparam int VGA_CELLS  = VGA_COLS * VGA_ROWS;

  localparam int VGA_BLINK_FRAMES = 32;

  typedef logic [11:0] rgb12_t;

  typedef struct packed {
    logic [2:0] hlo;
    logic [3:0] vlo;
    logic       act;
    logic       hs;
    logic       vs;
  } pix_tag_t;

  localparam pix_tag_t TAG_RST = '{
    hlo: 3'd0, vlo: 4'd0, act: 1'b0, hs: 1'b1, vs: 1'b1
  };

  // row*80 without a multiplier
  function automatic logic [11:0] cell_addr(
    input logic [5:0] row,
    input logic [6:0] col
  );
    logic [11:0] r;
    r = {6'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/vga_text_renderer_timing.sv
// Pixel/line counters, raw syncs, active window and frame pulse.
// Everything advances only on pix_ce.
module vga_timing_gen
  import vga_text_renderer_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active_raw,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       frame_start_q, frame_start_d;
  logic       h_last, v_last;

  always_comb begin
    h_last        = hcnt_q == H_LAST;
    v_last        = vcnt_q == V_LAST;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      hcnt_d = h_last ? 10'd0 : hcnt_q + 10'd1;
      if (h_last) begin
        vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
      end
      frame_start_d = h_last && v_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync_raw   = !(hcnt_q >= HS_LO && hcnt_q <= HS_HI);
  assign vsync_raw   = !(vcnt_q >= VS_LO && vcnt_q <= VS_HI);
  assign active_raw  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA renderer: cell fetch, glyph fetch, pixel serialise
// with a blinking underline cursor; 3 pix_ce ticks of latency.
module vga_text_renderer
  import vga_text_renderer_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int BLINK_FRAMES = VGA_BLINK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [11:0] fg_color,
  input  logic [11:0] cursor_pos,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  logic [9:0] hcnt, vcnt;
  logic       hs_raw, vs_raw, act_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync_raw   (hs_raw),
    .vsync_raw   (vs_raw),
    .active_raw  (act_raw),
    .frame_start (frame_start)
  );

  logic [11:0] text_addr_q, text_addr_d;
  logic [11:0] font_addr_q, font_addr_d;
  pix_tag_t    tag1_q, tag1_d;
  pix_tag_t    tag2_q, tag2_d;
  logic        hit_q, hit_d;
  rgb12_t      rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic        glyph_bit, cursor_on, pixel_on;

  always_comb begin
    text_addr_d = text_addr_q;
    font_addr_d = font_addr_q;
    tag1_d      = tag1_q;
    tag2_d      = tag2_q;
    hit_d       = hit_q;
    rgb_d       = rgb_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    // bit 7 is the leftmost pixel, so index by the inverted column
    glyph_bit = font_data[~tag2_q.hlo];
    cursor_on = hit_q & blink_q & (tag2_q.vlo >= 4'd14);
    pixel_on  = glyph_bit ^ cursor_on;
    if (pix_ce) begin
      text_addr_d = act_raw ?
        cell_addr(vcnt[9:4], hcnt[9:3]) : 12'd0;
      tag1_d = '{
        hlo: hcnt[2:0], vlo: vcnt[3:0],
        act: act_raw, hs: hs_raw, vs: vs_raw
      };
      font_addr_d = {text_data, tag1_q.vlo};
      hit_d       = text_addr_q == cursor_pos;
      tag2_d      = tag1_q;
      rgb_d       = (pixel_on && tag2_q.act) ? fg_color : 12'd0;
      hs_d        = tag2_q.hs;
      vs_d        = tag2_q.vs;
    end
    if (frame_start) begin
      if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      text_addr_q <= 12'd0;
      font_addr_q <= 12'd0;
      tag1_q      <= TAG_RST;
      tag2_q      <= TAG_RST;
      hit_q       <= 1'b0;
      rgb_q       <= 12'd0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign vga_r     = rgb_q[11:8];
  assign vga_g     = rgb_q[7:4];
  assign vga_b     = rgb_q[3:0];
  assign hsync     = hs_q;
  assign vsync     = vs_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer on a shrunken 96x40 raster.
// Reference model works from raster position and cell maths.
module tb_vga_text_renderer;

  localparam int HA = 64, HF = 8, HSY = 16, HB = 8;
  localparam int VA = 32, VF = 2, VSY = 2, VB = 4;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [11:0] text_addr, font_addr, fg_color, cursor_pos;
  logic [7:0]  text_data, font_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  logic [7:0] tmem [2400];
  logic [7:0] fmem [4096];

  int n;
  int passed;
  int total;

  always #5 clk = ~clk;

  assign text_data = (text_addr < 12'd2400) ? tmem[text_addr] : 8'h00;
  assign font_data = fmem[font_addr];
  assign rgb = {vga_r, vga_g, vga_b};

  vga_text_renderer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk), .rst (rst), .pix_ce (pix_ce),
    .text_addr (text_addr), .text_data (text_data),
    .font_addr (font_addr), .font_data (font_data),
    .fg_color (fg_color), .cursor_pos (cursor_pos),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .hsync (hsync), .vsync (vsync), .frame_start (frame_start)
  );

  task automatic tick(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    if (ce && !rst) n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic fill_glyph();
    foreach (tmem[i]) tmem[i] = 8'h41;
    foreach (fmem[i]) fmem[i] = ((i >> 4) == 'h41) ? 8'h81 : 8'h00;
  endtask

  task automatic fill_random();
    foreach (tmem[i]) tmem[i] = 8'($urandom);
    foreach (fmem[i]) fmem[i] = 8'($urandom);
  endtask

  function automatic int m_cell(input int q);
    int h, v;
    if (q < 0) return -1;
    h = q % HT;
    v = (q / HT) % VT;
    if (h >= HA || v >= VA) return -1;
    return (v / 16) * 80 + h / 8;
  endfunction

  function automatic logic [11:0] m_rgb(input int nn);
    int q, h, v, f, c;
    logic [7:0] g;
    logic on;
    q = nn - 3;
    c = m_cell(q);
    if (c < 0) return 12'h000;
    h = q % HT;
    v = (q / HT) % VT;
    f = q / FT;
    g = fmem[{tmem[c], 4'(v % 16)}];
    on = g[7 - (h % 8)] ^ (c == int'(cursor_pos) &&
         ((f / BF) % 2 == 1) && (v % 16) >= 14);
    return on ? fg_color : 12'h000;
  endfunction

  function automatic logic m_hs(input int nn);
    int h;
    if (nn < 3) return 1'b1;
    h = (nn - 3) % HT;
    return !(h >= HA + HF && h < HA + HF + HSY);
  endfunction

  function automatic logic m_vs(input int nn);
    int v;
    if (nn < 3) return 1'b1;
    v = ((nn - 3) / HT) % VT;
    return !(v >= VA + VF && v < VA + VF + VSY);
  endfunction

  task automatic test_reset();
    foreach (tmem[i]) tmem[i] = 8'h41;
    foreach (fmem[i]) fmem[i] = 8'hFF;
    fg_color = 12'hFFF;
    cursor_pos = 12'd2400;
    do_reset();
    for (int i = 0; i < 120; i++) tick(1'b1);
    rst = 1'b1;
    tick(1'b0);
    total++;
    if (rgb !== 12'h000)
      $display("FAIL reset_rgb got %h want 000", rgb);
    else passed++;
    total++;
    if (hsync !== 1'b1)
      $display("FAIL reset_hsync got %b want 1", hsync);
    else passed++;
    total++;
    if (vsync !== 1'b1)
      $display("FAIL reset_vsync got %b want 1", vsync);
    else passed++;
    total++;
    if (frame_start !== 1'b0)
      $display("FAIL reset_fs got %b want 0", frame_start);
    else passed++;
    total++;
    if (text_addr !== 12'd0)
      $display("FAIL reset_taddr got %0d want 0", text_addr);
    else passed++;
    total++;
    if (font_addr !== 12'd0)
      $display("FAIL reset_faddr got %h want 000", font_addr);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_timing();
    int hs_bad = 0, vs_bad = 0, fs_bad = 0, bad_n = -1;
    int first_fall = -1, hs_low = 0, vs_low = 0;
    int fs0 = -1, fs1 = -1;
    fill_glyph();
    do_reset();
    for (int i = 0; i < 2 * FT + 1; i++) begin
      tick(1'b1);
      if (hsync !== m_hs(n)) begin
        hs_bad++;
        if (bad_n < 0) bad_n = n;
      end
      if (vsync !== m_vs(n)) vs_bad++;
      if (frame_start !== (n % FT == 0)) fs_bad++;
      if (hsync == 1'b0 && first_fall < 0) first_fall = n;
      if (hsync == 1'b0 && n - 3 >= HT && n - 3 < 2 * HT) hs_low++;
      if (vsync == 1'b0 && n - 3 < FT) vs_low++;
      if (frame_start) begin
        if (fs0 < 0) fs0 = n;
        else if (fs1 < 0) fs1 = n;
      end
    end
    total++;
    if (hs_bad !== 0)
      $display("FAIL hsync_seq got %0d bad ticks (first %0d) want 0",
               hs_bad, bad_n);
    else passed++;
    total++;
    if (vs_bad !== 0)
      $display("FAIL vsync_seq got %0d bad ticks want 0", vs_bad);
    else passed++;
    total++;
    if (fs_bad !== 0)
      $display("FAIL fs_seq got %0d bad ticks want 0", fs_bad);
    else passed++;
    total++;
    if (first_fall !== HA + HF + 3)
      $display("FAIL hsync_first got %0d want %0d",
               first_fall, HA + HF + 3);
    else passed++;
    total++;
    if (hs_low !== HSY)
      $display("FAIL hsync_width got %0d want %0d", hs_low, HSY);
    else passed++;
    total++;
    if (vs_low !== VSY * HT)
      $display("FAIL vsync_width got %0d want %0d", vs_low, VSY * HT);
    else passed++;
    total++;
    if (fs1 - fs0 !== FT || fs0 < 0)
      $display("FAIL fs_period got %0d want %0d", fs1 - fs0, FT);
    else passed++;
  endtask

  task automatic test_glyph();
    int bad = 0, bad_n = -1, lit = 0, q, h;
    logic [11:0] exp_c, got0;
    fill_glyph();
    fg_color = 12'hFFF;
    cursor_pos = 12'd2400;
    do_reset();
    got0 = 12'h000;
    for (int i = 0; i < 3 * HT; i++) begin
      tick(1'b1);
      q = n - 3;
      h = (q < 0) ? HT : q % HT;
      exp_c = (h < HA && (h % 8 == 0 || h % 8 == 7)) ? 12'hFFF : 12'h000;
      if (rgb !== exp_c) begin
        bad++;
        if (bad_n < 0) bad_n = n;
      end
      if (n == 3) got0 = rgb;
      if (q >= 0 && q < HT && rgb != 12'h000) lit++;
    end
    total++;
    if (got0 !== 12'hFFF)
      $display("FAIL glyph_first got %h want FFF", got0);
    else passed++;
    total++;
    if (bad !== 0)
      $display("FAIL glyph_pattern got %0d bad (first %0d) want 0",
               bad, bad_n);
    else passed++;
    total++;
    if (lit !== 2 * (HA / 8))
      $display("FAIL glyph_lit got %0d want %0d", lit, 2 * (HA / 8));
    else passed++;
  endtask

  task automatic test_slow_ce();
    int rgb_bad = 0, hs_bad = 0, fs_bad = 0, f0 = -1, f1 = -1;
    logic prev_hs;
    fill_glyph();
    fg_color = 12'hFFF;
    cursor_pos = 12'd2400;
    do_reset();
    prev_hs = 1'b1;
    for (int k = 0; k < 4 * HT * 3; k++) begin
      tick(k % 4 == 3);
      if (rgb !== m_rgb(n)) rgb_bad++;
      if (hsync !== m_hs(n)) hs_bad++;
      if (frame_start !== 1'b0) fs_bad++;
      if (prev_hs && !hsync) begin
        if (f0 < 0) f0 = k;
        else if (f1 < 0) f1 = k;
      end
      prev_hs = hsync;
    end
    total++;
    if (rgb_bad !== 0)
      $display("FAIL slow_rgb got %0d bad clks want 0", rgb_bad);
    else passed++;
    total++;
    if (hs_bad + fs_bad !== 0)
      $display("FAIL slow_sync got %0d bad clks want 0", hs_bad + fs_bad);
    else passed++;
    total++;
    if (f1 - f0 !== 4 * HT || f0 < 0)
      $display("FAIL slow_line got %0d want %0d", f1 - f0, 4 * HT);
    else passed++;
  endtask

  task automatic test_addressing();
    int ta_bad = 0, fa_bad = 0, rgb_bad = 0, c1, c2, v2;
    logic [11:0] ta_last, ta_81, fa_last;
    fill_random();
    fg_color = 12'($urandom) | 12'h001;
    cursor_pos = 12'd2400;
    do_reset();
    ta_last = 12'hFFF;
    ta_81 = 12'hFFF;
    fa_last = 12'hFFF;
    for (int i = 0; i < FT + 2; i++) begin
      tick(1'b1);
      c1 = m_cell(n - 1);
      c2 = m_cell(n - 2);
      if (c1 >= 0 && text_addr !== 12'(c1)) ta_bad++;
      if (c2 >= 0) begin
        v2 = ((n - 2) / HT) % VT;
        if (font_addr !== {tmem[c2], 4'(v2 % 16)}) fa_bad++;
      end
      if (n - 1 == (VA - 1) * HT + HA - 1) ta_last = text_addr;
      if (n - 1 == 16 * HT + 8) ta_81 = text_addr;
      if (n - 2 == (VA - 1) * HT + 20) fa_last = font_addr;
      if (rgb !== m_rgb(n)) rgb_bad++;
    end
    total++;
    if (ta_bad !== 0)
      $display("FAIL taddr_seq got %0d bad want 0", ta_bad);
    else passed++;
    total++;
    if (fa_bad !== 0)
      $display("FAIL faddr_seq got %0d bad want 0", fa_bad);
    else passed++;
    total++;
    if (ta_last !== 12'd87)
      $display("FAIL taddr_corner got %0d want 87", ta_last);
    else passed++;
    total++;
    if (ta_81 !== 12'd81)
      $display("FAIL taddr_8_16 got %0d want 81", ta_81);
    else passed++;
    total++;
    if (fa_last !== {tmem[82], 4'd15})
      $display("FAIL faddr_lastrow got %h want %h",
               fa_last, {tmem[82], 4'd15});
    else passed++;
    total++;
    if (rgb_bad !== 0)
      $display("FAIL rand_rgb got %0d bad want 0", rgb_bad);
    else passed++;
  endtask

  task automatic test_cursor();
    int lit, exp_lit, rgb_bad = 0;
    foreach (tmem[i]) tmem[i] = 8'($urandom);
    foreach (fmem[i]) fmem[i] = 8'h00;
    fg_color = 12'($urandom) | 12'h001;
    cursor_pos = 12'd81;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      if (f == 6) cursor_pos = 12'd2400;
      lit = 0;
      for (int i = 0; i < FT; i++) begin
        tick(1'b1);
        if (rgb != 12'h000) lit++;
        if (rgb !== m_rgb(n)) rgb_bad++;
      end
      exp_lit = (f < 6 && (f / BF) % 2 == 1) ? 16 : 0;
      total++;
      if (lit !== exp_lit)
        $display("FAIL cursor_frame%0d got %0d lit want %0d",
                 f, lit, exp_lit);
      else passed++;
    end
    total++;
    if (rgb_bad !== 0)
      $display("FAIL cursor_rgb got %0d bad want 0", rgb_bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int fs_n = -1, rgb_bad = 0;
    foreach (tmem[i]) tmem[i] = 8'($urandom);
    foreach (fmem[i]) fmem[i] = 8'hFF;
    fg_color = 12'hFFF;
    cursor_pos = 12'd2400;
    do_reset();
    for (int i = 0; i < 200 * 0 + 20 * HT + 30; i++) tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    total++;
    if (rgb !== 12'h000)
      $display("FAIL midrst_rgb got %h want 000", rgb);
    else passed++;
    total++;
    if ({hsync, vsync} !== 2'b11)
      $display("FAIL midrst_sync got %b want 11", {hsync, vsync});
    else passed++;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < FT + 4 && fs_n < 0; i++) begin
      tick(1'b1);
      if (rgb !== m_rgb(n)) rgb_bad++;
      if (frame_start) fs_n = n;
    end
    total++;
    if (fs_n !== FT)
      $display("FAIL midrst_fs got %0d want %0d", fs_n, FT);
    else passed++;
    total++;
    if (rgb_bad !== 0)
      $display("FAIL midrst_rgb_seq got %0d bad want 0", rgb_bad);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    n = 0;
    fg_color = 12'h000;
    cursor_pos = 12'd2400;
    test_reset();
    test_timing();
    test_glyph();
    test_slow_ce();
    test_addressing();
    test_cursor();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Downstream consumer of the core-plus-RAM block: scans the 80x30 character buffer that the core writes and drives a 640x480@60 VGA output.
- Generates the sync timing and reads the character code from the text RAM read port.
- Looks up the glyph row in an external font ROM and serialises the glyph pixels with a blinking cursor overlay.
- Runs on the system clock and advances one pixel per pix_ce.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- COLS, 80, characters per row
- BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; all timing and pipeline state advances only when high
- text_addr  out  12  text RAM read address = row*COLS + col
- text_data  in  8  character code, valid one clk after text_addr
- font_addr  out  12  {char[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row bits, bit 7 = leftmost pixel, valid one clk after font_addr
- fg_color  in  12  foreground colour {R,G,B} 4 bits each
- cursor_pos  in  12  cell index of cursor; values >= 2400 disable the cursor
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- hsync, vsync  out  1 each  active-low syncs
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Reset (sync, high) forces:
  - hcnt = 0, vcnt = 0, pipeline valid bits cleared, blink counter = 0, blink phase = 0.
  - rgb = 0, hsync = 1, vsync = 1, frame_start = 0, text_addr = 0, font_addr = 0.
- A reset asserted mid-frame takes effect on that clk edge regardless of pix_ce. The first line after reset restarts at (0,0).
- Counters (update on pix_ce only):
  - hcnt runs 0..799, then wraps to 0 and increments vcnt.
  - vcnt runs 0..524, then wraps to 0.
- Stage 0 (on pix_ce): text_addr = (vcnt>>4)*80 + (hcnt>>3), registered. The multiply is done as (r<<6)+(r<<4). Outside the active area the address is don't-care but must be < 2400.
- Stage 1 (next pix_ce):
  - Capture text_data.
  - font_addr = {text_data, vcnt_d1[3:0]}.
  - Register the cursor hit = (text_addr_d1 == cursor_pos).
- Stage 2 (next pix_ce):
  - Capture font_data and select bit = font_data[7 - hcnt_d2[2:0]].
  - pixel_on = bit XOR (cursor_hit_d2 AND blink_phase AND vcnt_d2[3:0] >= 14). The cursor is an underline on glyph rows 14-15.
- Output register (third pix_ce):
  - rgb = fg_color if pixel_on and active_d3, else 0.
- Total latency from counter position to rgb/sync is 3 pix_ce ticks.
- hsync/vsync/active are derived from the undelayed counters and delayed 3 ticks, so sync edges stay aligned with pixels.
  - hsync is low for hcnt in [656, 751].
  - vsync is low for vcnt in [490, 491].
  - active = hcnt < 640 and vcnt < 480.
- frame_start: one-clk pulse on the clk where pix_ce=1 and the counters wrap from (799,524) to (0,0). It is undelayed.
- Blink:
  - The frame counter increments on each frame_start.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
- pix_ce low: every register holds. The RAM/ROM data is registered by the source and held, so sampling on the next pix_ce is valid.
- pix_ce held high permanently is legal (clk is the pixel clock).
- cursor_pos changing mid-frame is sampled per cell at stage 1, with no glitch handling beyond that.

Decomposition:
- Shared package holds the VGA timing constants (H/V totals, sync start/end), COLS/ROWS, CHAR_W=8, CHAR_H=16 and a 12-bit colour typedef.
- One natural sub-module, vga_timing_gen, provides hcnt, vcnt, raw hsync/vsync/active and frame_start.
- The renderer pipeline stays in the top module.

Test Plan:
- Timing: hold pix_ce=1 and release rst at t0.
  - hsync low for exactly 96 clks per 800-clk line, first falling edge at clk 656+3.
  - vsync low for 2 lines per 525.
  - frame_start period = 420000 clks.
- Glyph path: text RAM model all 0x41, font ROM returns 0x81 for char 0x41, fg_color=0xFFF.
  - Line 0 rgb = FFF,0,0,0,0,0,0,FFF repeating, first pixel 3 clks after hcnt=0.
  - rgb = 0 during blanking.
- Addressing: check text_addr at pixel (x=639, y=479) = 2399 and at (x=8, y=16) = 81.
  - Check font_addr = {code,4'd15} on line 479.
- Cursor: cursor_pos=81, font all zero, BLINK_FRAMES=2.
  - Lines 30-31, pixels 8-15 lit only in frames where blink_phase=1 (toggles every 2 frames).
  - cursor_pos=2400 gives no lit pixels.
- pix_ce=1 every 4th clk: outputs change only on pix_ce clks.
  - Line period = 3200 clks; pixel pattern identical to the glyph-path case.
- Reset mid-frame: assert rst at hcnt=300, vcnt=200 for 1 clk.
  - Next clk: rgb=0, hsync=vsync=1.
  - hcnt restarts at 0, and the next frame_start follows 420000 pix_ce ticks later.
